// File: rtl/redirect_ctrl.sv
// Hazard and forwarding control for the 5-stage redirect pipeline.
// Tracks destination tags through EX/MEM/WB; drives bypass, stall, flush.
module redirect_ctrl #(
  parameter int         CNT_W    = 16,
  parameter logic [4:0] ZERO_REG = 5'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_ra,
  input  logic [4:0]       id_rb,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic [4:0]       id_rw,
  input  logic             id_regwe,
  input  logic             id_memtoreg,
  input  logic             ex_branch_taken,
  input  logic             halt,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       v;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       use_ra;
    logic       use_rb;
    logic [4:0] rw;
    logic       we;
    logic       ld;
  } ex_tag_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rw;
    logic       we;
  } wr_tag_t;

  ex_tag_t ex_q, ex_d;
  wr_tag_t mem_q, mem_d;
  wr_tag_t wb_q, wb_d;
  logic    lu;
  logic    sel_halt, sel_flush, sel_stall, sel_run;

  function automatic logic writes(wr_tag_t t, logic [4:0] r);
    return t.v && t.we && (t.rw == r) && (r != ZERO_REG);
  endfunction

  always_comb begin
    fwd_a = 2'd0;
    if (ex_q.use_ra && writes(mem_q, ex_q.ra))
      fwd_a = 2'd1;
    else if (ex_q.use_ra && writes(wb_q, ex_q.ra))
      fwd_a = 2'd2;
  end

  always_comb begin
    fwd_b = 2'd0;
    if (ex_q.use_rb && writes(mem_q, ex_q.rb))
      fwd_b = 2'd1;
    else if (ex_q.use_rb && writes(wb_q, ex_q.rb))
      fwd_b = 2'd2;
  end

  assign lu = id_valid && ex_q.v && ex_q.we && ex_q.ld
           && (ex_q.rw != ZERO_REG)
           && ((id_use_ra && id_ra == ex_q.rw)
            || (id_use_rb && id_rb == ex_q.rw));

  // one-hot action selects; halt > branch > load-use > run
  assign sel_halt  = halt;
  assign sel_flush = !halt && ex_branch_taken;
  assign sel_stall = !halt && !ex_branch_taken && lu;
  assign sel_run   = !halt && !ex_branch_taken && !lu;

  assign stall = sel_halt || sel_stall;
  assign flush = sel_flush;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    unique case (1'b1)
      sel_halt: ;
      sel_flush, sel_stall: begin
        ex_d  = '0;
        mem_d = '{v: ex_q.v, rw: ex_q.rw, we: ex_q.we};
        wb_d  = mem_q;
      end
      sel_run: begin
        ex_d  = '{v: id_valid, ra: id_ra, rb: id_rb,
                  use_ra: id_use_ra, use_rb: id_use_rb,
                  rw: id_rw, we: id_regwe, ld: id_memtoreg};
        mem_d = '{v: ex_q.v, rw: ex_q.rw, we: ex_q.we};
        wb_d  = mem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (sel_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (sel_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl: forwarding, load-use,
// branch priority, halt freeze, async reset, counter saturation.
module tb_redirect_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_ra, id_rb, id_rw;
  logic             id_use_ra, id_use_rb;
  logic             id_regwe, id_memtoreg;
  logic             ex_branch_taken, halt;
  logic [1:0]       fwd_a, fwd_b;
  logic             stall, flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  redirect_ctrl #(.CNT_W(CNT_W), .ZERO_REG(5'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .id_rw(id_rw), .id_regwe(id_regwe), .id_memtoreg(id_memtoreg),
    .ex_branch_taken(ex_branch_taken), .halt(halt),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra,
                       input logic [4:0] rb, input logic ura,
                       input logic urb, input logic [4:0] rw,
                       input logic we, input logic ld);
    id_valid = v; id_ra = ra; id_rb = rb;
    id_use_ra = ura; id_use_rb = urb;
    id_rw = rw; id_regwe = we; id_memtoreg = ld;
    #1;
  endtask

  task automatic idle();
    ex_branch_taken = 1'b0;
    halt = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    halt = 1'b1;
    #2;
    total++;
    if (stall !== 1'b1) begin
      bad++; $display("FAIL reset_halt_stall: got %b want 1", stall);
    end
    halt = 1'b0;
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if (flush !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL reset_br_flush: got f=%b s=%b want 1 0", flush, stall);
    end
    ex_branch_taken = 1'b0;
    #1;
    total++;
    if ({fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got fa=%0d fb=%0d s=%b f=%b sc=%0d fc=%0d want 0",
               fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_chain();
    do_reset();
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    drive(1, 3, 3, 1, 1, 4, 1, 0);
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL alu_nostall: got %b want 0", stall);
    end
    tick();
    total++;
    if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin
      bad++; $display("FAIL alu_fwd1: got %0d/%0d want 1/1", fwd_a, fwd_b);
    end
    drive(1, 3, 0, 1, 1, 7, 1, 0);
    tick();
    total++;
    if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      bad++; $display("FAIL alu_fwd2: got %0d/%0d want 2/0", fwd_a, fwd_b);
    end
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 0, 1, 1, 6, 1, 0);
    total++;
    if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
      bad++; $display("FAIL lu_stall: got s=%b c=%0d want 1 0", stall, stall_cnt);
    end
    tick();
    total++;
    if (stall !== 1'b0 || stall_cnt !== 4'd1) begin
      bad++; $display("FAIL lu_one_cycle: got s=%b c=%0d want 0 1", stall, stall_cnt);
    end
    tick();
    total++;
    if (fwd_a !== 2'd2 || fwd_b !== 2'd0 || stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL lu_fwd: got %0d/%0d c=%0d want 2/0 1", fwd_a, fwd_b, stall_cnt);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 1, 0, 1, 0, 0, 1, 1);
    tick();
    drive(1, 0, 0, 1, 1, 8, 1, 0);
    total++;
    if (stall !== 1'b0) begin
      bad++; $display("FAIL zero_stall: got %b want 0", stall);
    end
    tick();
    total++;
    if (fwd_a !== 2'd0 || fwd_b !== 2'd0 || stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL zero_fwd: got %0d/%0d c=%0d want 0/0 0", fwd_a, fwd_b, stall_cnt);
    end
    idle();
  endtask

  task automatic test_branch_vs_lu();
    do_reset();
    drive(1, 1, 0, 1, 0, 5, 1, 1);
    tick();
    drive(1, 5, 5, 1, 1, 6, 1, 0);
    ex_branch_taken = 1'b1;
    #1;
    total++;
    if (flush !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL br_prio: got f=%b s=%b want 1 0", flush, stall);
    end
    tick();
    ex_branch_taken = 1'b0;
    #1;
    total++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      bad++; $display("FAIL br_cnt: got fc=%0d sc=%0d want 1 0", flush_cnt, stall_cnt);
    end
    total++;
    if (stall !== 1'b0 || flush !== 1'b0 || fwd_a !== 2'd0) begin
      bad++;
      $display("FAIL br_bubble: got s=%b f=%b fa=%0d want 0 0 0", stall, flush, fwd_a);
    end
    idle();
  endtask

  task automatic test_halt_reset();
    do_reset();
    ex_branch_taken = 1'b1;
    tick();
    ex_branch_taken = 1'b0;
    drive(1, 1, 2, 1, 1, 3, 1, 0);
    tick();
    drive(1, 3, 3, 1, 1, 4, 1, 0);
    tick();
    drive(1, 3, 0, 1, 1, 7, 1, 0);
    halt = 1'b1;
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall !== 1'b1 || flush !== 1'b0 || fwd_a !== 2'd1 || fwd_b !== 2'd1
          || flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
        bad++;
        $display("FAIL halt_freeze%0d: got s=%b f=%b fwd=%0d/%0d fc=%0d sc=%0d want 1 0 1/1 1 0",
                 i, stall, flush, fwd_a, fwd_b, flush_cnt, stall_cnt);
      end
      tick();
    end
    halt = 1'b0;
    ex_branch_taken = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || fwd_a !== 2'd1 || fwd_b !== 2'd1 || flush_cnt !== 4'd1) begin
      bad++;
      $display("FAIL halt_resume: got s=%b fwd=%0d/%0d fc=%0d want 0 1/1 1",
               stall, fwd_a, fwd_b, flush_cnt);
    end
    tick();
    total++;
    if (fwd_a !== 2'd2 || fwd_b !== 2'd0) begin
      bad++; $display("FAIL halt_after: got %0d/%0d want 2/0", fwd_a, fwd_b);
    end
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt} !== '0) begin
      bad++;
      $display("FAIL async_rst: got fa=%0d fb=%0d s=%b f=%b sc=%0d fc=%0d want 0",
               fwd_a, fwd_b, stall, flush, stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_saturation();
    int seen;
    seen = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 0, 5, 1, 1);
      tick();
      drive(1, 0, 5, 1, 1, 6, 1, 0);
      if (stall === 1'b1) seen++;
      tick();
      if (i == 14) begin
        total++;
        if (stall_cnt !== 4'd15) begin
          bad++; $display("FAIL sat_reach: got %0d want 15", stall_cnt);
        end
      end
    end
    total++;
    if (seen != 20) begin
      bad++; $display("FAIL sat_stalls: got %0d want 20", seen);
    end
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_alu_chain();
    test_load_use();
    test_zero_reg();
    test_branch_vs_lu();
    test_halt_reset();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
